// File: rtl/radio_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : radio_serializer_if
// Description : Radio sample inputs, control and serial outputs of the
//               radio serializer, bundled with master/slave views.
// Revision    : 1.0
// ============================================================================
interface radio_serializer_if #(
    parameter int NUM_RADIOS = 2,
    parameter int BITS       = 2
);
    logic [NUM_RADIOS*BITS-1:0] RX_I;
    logic [NUM_RADIOS*BITS-1:0] RX_Q;
    logic [1:0]                 MODE;
    logic                       ENABLE;
    logic                       DATA_OUT;
    logic                       SYNC;
    logic                       MISC;

    modport master (
        output RX_I, RX_Q, MODE, ENABLE,
        input  DATA_OUT, SYNC, MISC
    );

    modport slave (
        input  RX_I, RX_Q, MODE, ENABLE,
        output DATA_OUT, SYNC, MISC
    );
endinterface
`default_nettype wire

// File: rtl/radio_serializer.sv
`default_nettype none
// ============================================================================
// Module      : radio_serializer
// Description : Packs per-radio I/Q samples into W-bit frames and shifts them
//               out MSB-first with a SYNC marker; test-pattern/heartbeat modes.
// Revision    : 1.0
// ============================================================================
module radio_serializer #(
    parameter int NUM_RADIOS = 2,
    parameter int BITS       = 2,
    parameter int HB_W       = 26,
    parameter int HB_BIT     = 23
) (
    input  wire logic          DATA_CLK,
    input  wire logic          RST,
    radio_serializer_if.slave  bus
);
    localparam int W  = 2 * NUM_RADIOS * BITS;
    localparam int CW = $clog2(W);

    localparam logic [1:0] c_MODE_RADIO = 2'd0;
    localparam logic [1:0] c_MODE_COUNT = 2'd1;
    localparam logic [1:0] c_MODE_ALT   = 2'd2;
    localparam logic [1:0] c_MODE_HB    = 2'd3;

    logic [W-1:0]    in_d;
    logic [W-1:0]    in_q;
    logic [W-1:0]    alt_d;
    logic [W-1:0]    word_d;
    logic [W-1:0]    shreg_q;
    logic [W-1:0]    pat_q;
    logic [HB_W-1:0] hb_q;
    logic [CW-1:0]   bit_cnt_q;
    logic            dout_q;
    logic            sync_q;

    // Radio r fills bits [2r*BITS +: 2*BITS], I above Q, highest radio on top.
    for (genvar r = 0; r < NUM_RADIOS; r++) begin : g_pack
        assign in_d[(2*r+1)*BITS +: BITS] = bus.RX_I[r*BITS +: BITS];
        assign in_d[(2*r)*BITS   +: BITS] = bus.RX_Q[r*BITS +: BITS];
    end

    // 1010... from the MSB; an odd width naturally ends on a 1.
    for (genvar i = 0; i < W; i++) begin : g_alt
        assign alt_d[i] = (((W - 1 - i) % 2) == 0);
    end

    always_comb begin
        word_d = in_q;
        case (bus.MODE)
            c_MODE_RADIO: word_d = in_q;
            c_MODE_COUNT: word_d = pat_q;
            c_MODE_ALT:   word_d = alt_d;
            c_MODE_HB:    word_d = {W{hb_q[HB_BIT]}};
            default:      word_d = in_q;
        endcase
    end

    always_ff @(posedge DATA_CLK or posedge RST) begin
        if (RST) begin
            in_q      <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pat_q     <= '0;
            hb_q      <= '0;
            dout_q    <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            in_q <= in_d;
            hb_q <= hb_q + 1'b1;
            if (!bus.ENABLE) begin
                bit_cnt_q <= '0;
                shreg_q   <= '0;
                dout_q    <= 1'b0;
                sync_q    <= 1'b0;
            end else if (bit_cnt_q == '0) begin
                dout_q    <= word_d[W-1];
                shreg_q   <= {word_d[W-2:0], 1'b0};
                sync_q    <= 1'b1;
                bit_cnt_q <= CW'(1);
                if (bus.MODE == c_MODE_COUNT) begin
                    pat_q <= pat_q + 1'b1;
                end
            end else begin
                dout_q    <= shreg_q[W-1];
                shreg_q   <= {shreg_q[W-2:0], 1'b0};
                sync_q    <= 1'b0;
                bit_cnt_q <= (bit_cnt_q == CW'(W - 1)) ? '0 : bit_cnt_q + 1'b1;
            end
        end
    end

    assign bus.DATA_OUT = dout_q;
    assign bus.SYNC     = sync_q;
    assign bus.MISC     = hb_q[HB_BIT];
endmodule
`default_nettype wire

// File: tb/tb_radio_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_radio_serializer
// Description : Scoreboard bench for radio_serializer; a 2x2-bit and a 4x1-bit
//               instance run side by side with a 4-bit heartbeat tap.
// Revision    : 1.0
// ============================================================================
module tb_radio_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       en;
    logic [3:0] rxi;
    logic [3:0] rxq;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic d;
        logic s;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] pat_m;
    logic [7:0] hb_m;

    always #5 clk = ~clk;

    radio_serializer_if #(.NUM_RADIOS(2), .BITS(2)) ifa ();
    radio_serializer_if #(.NUM_RADIOS(4), .BITS(1)) ifb ();

    assign ifa.RX_I   = rxi;
    assign ifa.RX_Q   = rxq;
    assign ifa.MODE   = mode;
    assign ifa.ENABLE = en;
    assign ifb.RX_I   = rxi;
    assign ifb.RX_Q   = rxq;
    assign ifb.MODE   = mode;
    assign ifb.ENABLE = en;

    radio_serializer #(.NUM_RADIOS(2), .BITS(2), .HB_W(26), .HB_BIT(3)) u_dut_a (
        .DATA_CLK (clk),
        .RST      (rst),
        .bus      (ifa)
    );

    radio_serializer #(.NUM_RADIOS(4), .BITS(1), .HB_W(26), .HB_BIT(3)) u_dut_b (
        .DATA_CLK (clk),
        .RST      (rst),
        .bus      (ifb)
    );

    // Heartbeat reference: cycles elapsed since the last reset.
    always @(posedge clk or posedge rst) begin
        if (rst) hb_m <= '0;
        else     hb_m <= hb_m + 8'd1;
    end

    function automatic logic [7:0] pack_a(input logic [3:0] i, input logic [3:0] q);
        return {i[3:2], q[3:2], i[1:0], q[1:0]};
    endfunction

    function automatic logic [7:0] pack_b(input logic [3:0] i, input logic [3:0] q);
        return {i[3], q[3], i[2], q[2], i[1], q[1], i[0], q[0]};
    endfunction

    function automatic logic [7:0] word_for(input bit is_b);
        case (mode)
            2'd0:    return is_b ? pack_b(rxi, rxq) : pack_a(rxi, rxq);
            2'd1:    return pat_m;
            2'd2:    return 8'hAA;
            default: return {8{hb_m[3]}};
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called just before a load edge: queue the whole expected frame.
    task automatic load();
        logic [7:0] wa;
        logic [7:0] wb;
        wa = word_for(1'b0);
        wb = word_for(1'b1);
        for (int i = 0; i < 8; i++) begin
            qa.push_back('{d: wa[7-i], s: (i == 0)});
            qb.push_back('{d: wb[7-i], s: (i == 0)});
        end
        if (mode == 2'd1) pat_m = pat_m + 8'd1;
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (qa.size() == 0 || qb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL scoreboard_empty: observed size %0d/%0d expected >0", qa.size(), qb.size());
            end else begin
                e = qa.pop_front();
                chk("A_data", ifa.DATA_OUT, e.d);
                chk("A_sync", ifa.SYNC, e.s);
                e = qb.pop_front();
                chk("B_data", ifb.DATA_OUT, e.d);
                chk("B_sync", ifb.SYNC, e.s);
            end
            chk("A_misc", ifa.MISC, hb_m[3]);
            chk("B_misc", ifb.MISC, hb_m[3]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            qa.push_back('{d: 1'b0, s: 1'b0});
            qb.push_back('{d: 1'b0, s: 1'b0});
            run(1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_A_data"}, ifa.DATA_OUT, 1'b0);
        chk({tag, "_A_sync"}, ifa.SYNC, 1'b0);
        chk({tag, "_A_misc"}, ifa.MISC, 1'b0);
        chk({tag, "_B_data"}, ifb.DATA_OUT, 1'b0);
        chk({tag, "_B_sync"}, ifb.SYNC, 1'b0);
        chk({tag, "_B_misc"}, ifb.MISC, 1'b0);
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        rxi   = 4'b1110;
        rxq   = 4'b0001;
        pat_m = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Mode 0: steady inputs, then an RX change mid-frame
        en = 1'b1;
        load(); run(8);
        load(); run(3);
        rxi = 4'b1000;
        rxq = 4'b0101;
        run(5);
        load(); run(8);

        // Mode 1 counting, switch to mode 2 mid-frame
        mode = 2'd1;
        load(); run(8);
        load(); run(8);
        load(); run(3);
        mode = 2'd2;
        run(5);
        load(); run(8);

        // Enable dropped after bit 3, then a full frame on re-enable
        mode = 2'd1;
        load(); run(4);
        en = 1'b0;
        qa.delete();
        qb.delete();
        idle(3);
        en = 1'b1;
        load(); run(8);

        // Asynchronous reset mid-frame after five more mode-1 frames
        repeat (5) begin
            load(); run(8);
        end
        load(); run(3);
        #3 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        qa.delete();
        qb.delete();
        pat_m = '0;
        #2 rst = 1'b0;
        load(); run(8);

        // Mode 3: frames alternate all-1/all-0 with the heartbeat
        mode = 2'd3;
        repeat (3) begin
            load(); run(8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
